// File: rtl/sar_search_if.sv
// Handshake bundle between the SAR search engine and its comparison responder.
// The master side issues start and answers compares; the slave side is the engine.
interface sar_search_if #(
  parameter int W = 3
);
  logic         start;
  logic         gr;
  logic         le;
  logic         eq;
  logic         cmp_valid;
  logic [W-1:0] guess;
  logic         guess_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  modport master (
    output start, gr, le, eq, cmp_valid,
    input  guess, guess_valid, busy, done, result, err
  );

  modport slave (
    input  start, gr, le, eq, cmp_valid,
    output guess, guess_valid, busy, done, result, err
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search engine: walks a W-bit guess from MSB to LSB,
// narrowing on greater/less answers, stopping early on equal, aborting on an
// illegal compare code. All outputs are registered.
module sar_search #(
  parameter int W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  sar_search_if.slave bus
);
  localparam int IW = $clog2(W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  guess_q;
  logic [W-1:0]  result_q;
  logic          guess_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [W-1:0]  bit_cur;
  logic [W-1:0]  bit_nxt;
  logic          code_ok;

  // Masks for the bit under trial and the next one down, plus compare-code legality.
  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    bit_cur = W'(1) << idx;
    bit_nxt = bit_cur >> 1;
    code_ok = $onehot({bus.gr, bus.le, bus.eq});
  end

  // Search state machine; outputs are updated alongside the state they describe.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      guess_q       <= '0;
      result_q      <= '0;
      guess_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            guess_q       <= {1'b1, {(W-1){1'b0}}};
            idx           <= IW'(W - 1);
            guess_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.cmp_valid) begin
            if (!code_ok) begin
              guess_valid_q <= 1'b0;
              err_q         <= 1'b1;
              state         <= ST_ERR;
            end else if (bus.eq) begin
              result_q      <= guess_q;
              guess_valid_q <= 1'b0;
              done_q        <= 1'b1;
              state         <= ST_DONE;
            end else if (idx != '0) begin
              // Keep or clear the trial bit, then try the next lower bit.
              guess_q <= bus.gr ? (guess_q | bit_nxt) : ((guess_q & ~bit_cur) | bit_nxt);
              idx     <= idx - 1'b1;
            end else begin
              result_q      <= bus.gr ? guess_q : (guess_q & ~bit_cur);
              guess_valid_q <= 1'b0;
              done_q        <= 1'b1;
              state         <= ST_DONE;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.guess       = guess_q;
  assign bus.guess_valid = guess_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.err         = err_q;
endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter W, default 3, SHALL set the search word width in bits (W >= 2).
REQ-002 clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a new search when high in IDLE.
REQ-005 gr  input  1  SHALL mean the responder's target is greater than guess.
REQ-006 le  input  1  SHALL mean the responder's target is less than guess.
REQ-007 eq  input  1  SHALL mean the responder's target equals guess.
REQ-008 cmp_valid  input  1  SHALL qualify gr/le/eq for the current guess.
REQ-009 guess  output  W  SHALL carry the trial value under comparison.
REQ-010 guess_valid  output  1  SHALL be high while guess awaits a comparison result.
REQ-011 busy  output  1  SHALL be high in any state other than IDLE.
REQ-012 done  output  1  SHALL pulse for one cycle when result is final.
REQ-013 result  output  W  SHALL hold the recovered target, stable until the next start.
REQ-014 err  output  1  SHALL pulse for one cycle when a search aborts on an illegal compare code.

Function
REQ-015 States SHALL be IDLE, WAIT, DONE and ERR; all outputs registered.
REQ-016 IDLE + start: guess <= 1 followed by W-1 zeros (MSB only), bit index <= W-1, go to WAIT next edge.
REQ-017 WAIT SHALL drive guess_valid = 1; with cmp_valid low, state, guess and index SHALL hold.
REQ-018 WAIT + cmp_valid + eq: result <= guess, go to DONE (early termination).
REQ-019 WAIT + cmp_valid + gr, index > 0: keep bit[index], set bit[index-1], index decrements, stay in WAIT.
REQ-020 WAIT + cmp_valid + le, index > 0: clear bit[index], set bit[index-1], index decrements, stay in WAIT.
REQ-021 WAIT + cmp_valid + gr, index = 0: result <= guess, go to DONE.
REQ-022 WAIT + cmp_valid + le, index = 0: result <= guess with bit0 cleared, go to DONE.
REQ-023 A cmp_valid with gr/le/eq not exactly one-hot SHALL go to ERR; result unchanged.
REQ-024 DONE SHALL assert done for one cycle, then return to IDLE; ERR likewise asserts err for one cycle.
REQ-025 guess_valid SHALL be low in IDLE, DONE and ERR; guess SHALL hold its last value outside WAIT.
REQ-026 start outside IDLE SHALL be ignored; cmp_valid outside WAIT SHALL be ignored.
REQ-027 Latency: guess_valid rises one cycle after start is sampled.
REQ-028 With cmp_valid answered in the same cycle guess_valid is high, each comparison SHALL take exactly one cycle; worst case W comparisons.
REQ-029 done SHALL rise one cycle after the final comparison is sampled.
REQ-030 start sampled in the cycle DONE or ERR returns to IDLE SHALL be honored on the following edge, not the same one.

Reset
REQ-031 On rst_n low, state SHALL go to IDLE immediately; guess, result = 0; guess_valid, busy, done, err = 0.
REQ-032 Reset mid-search SHALL abandon the search with no done or err pulse; the first search after release SHALL start from MSB.
REQ-033 Outputs SHALL remain at reset values until the first clock edge with rst_n high and start high.

Verification
REQ-034 W=3, target 5, zero-wait responder: guesses 4(gr), 6(le), 5(eq) -> done, result=5, 3 compares.
REQ-035 W=3, target 0: guesses 4(le), 2(le), 1(le) -> result=0 via index-0 le rule; target 7: guesses 4, 6, 7(eq) -> result=7.
REQ-036 W=3, target 4: first guess 4 answered eq -> done after 1 compare, result=4.
REQ-037 Responder stalls cmp_valid for 5 cycles on the second guess -> guess stable, guess_valid high, busy high throughout.
REQ-038 cmp_valid with gr=le=1 -> err pulse for one cycle, return to IDLE, result keeps its previous value.
REQ-039 rst_n pulsed low during WAIT -> immediate IDLE, all outputs 0, no done; a new start searches target 3 -> result=3.
